mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader_pkg.sv | 23 ++
 rtl/mem_loader_if.sv | 39 +++
 rtl/mem_loader_checksum.sv | 35 +++
 rtl/mem_loader.sv | 187 ++++++++++++++++++
 tb/tb_mem_loader.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_loader_pkg.sv
// Shared constants and encodings for the memory loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_loader_pkg;

  localparam int REG_WIDTH  = 8;   // default memory word width
  localparam int ADDR_WIDTH = 16;  // default memory address width

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_CHECK  = 3'd3,
    ST_RUN    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_OVERFLOW = 2'b01,
    ERR_CHECKSUM = 2'b10
  } err_e;

endpackage

// File: rtl/mem_loader_if.sv
// Load stream, core-side request and memory-side port bundle for mem_loader.
// Latency: n/a (wires only).
// Backpressure: ld_valid/ld_ready handshake; memory and core sides have none.
// Ports: ld_valid/ld_ready/ld_data/ld_last (load beats), cpu_addr/cpu_we/cpu_din
// (core request), mem_addr/mem_we/mem_din (to memory), mem_dout (from memory).
// Package constants are referenced by scope because the parameters reuse the
// ADDR_WIDTH name.
interface mem_loader_if #(
  parameter int DATA_WIDTH = mem_loader_pkg::REG_WIDTH,
  parameter int ADDR_WIDTH = mem_loader_pkg::ADDR_WIDTH
) ();

  logic                  ld_valid;
  logic                  ld_ready;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_last;

  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic                  cpu_we;
  logic [DATA_WIDTH-1:0] cpu_din;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;

  // Environment side: beat source, core and memory model.
  modport master (
    output ld_valid, ld_data, ld_last, cpu_addr, cpu_we, cpu_din, mem_dout,
    input  ld_ready, mem_addr, mem_we, mem_din
  );

  // Loader side.
  modport slave (
    input  ld_valid, ld_data, ld_last, cpu_addr, cpu_we, cpu_din, mem_dout,
    output ld_ready, mem_addr, mem_we, mem_din
  );

endinterface

// File: rtl/mem_loader_checksum.sv
// Modular-sum accumulator: sum <= sum + data (mod 2^WIDTH) when enabled.
// Latency: sum reflects an enabled word on the edge after it is presented.
// Backpressure: none; clear takes priority over enable.
// Ports: clk, clear (synchronous zero), enable, data, sum.
module load_checksum
  import mem_loader_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = '0;
    end else if (enable) begin
      sum_d = sum_q + data;
    end
  end

  always_ff @(posedge clk) begin
    sum_q <= sum_d;
  end

  assign sum = sum_q;

endmodule

// File: rtl/mem_loader.sv
// Boot loader: streams beats into memory while holding the core, optionally
// reads them back to compare checksums, then releases the core onto memory.
// Latency: beat written same cycle; verify takes count+2 cycles to done.
// Backpressure: ld_ready high only in LOAD; core side has none.
// Ports: clk/reset, start/verify_en/base_addr (session request), bus (slave
// modport: load stream, core request, memory port), cpu_hold/busy/done/
// error/err_code/count (status).
module mem_loader #(
  parameter int DATA_WIDTH = mem_loader_pkg::REG_WIDTH,
  parameter int ADDR_WIDTH = mem_loader_pkg::ADDR_WIDTH,
  parameter int DEPTH      = 32,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  verify_en,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  mem_loader_if.slave           bus,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [CW-1:0]         count
);

  import mem_loader_pkg::state_e, mem_loader_pkg::err_e,
         mem_loader_pkg::ST_IDLE, mem_loader_pkg::ST_LOAD,
         mem_loader_pkg::ST_VERIFY, mem_loader_pkg::ST_CHECK,
         mem_loader_pkg::ST_RUN, mem_loader_pkg::ERR_NONE,
         mem_loader_pkg::ERR_OVERFLOW, mem_loader_pkg::ERR_CHECKSUM;

  state_e                state_q;
  err_e                  err_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic                  verify_q;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;
  logic [CW-1:0]         rd_cnt_q;
  logic                  rd_vld_q;   // mem_dout holds a verify read this cycle
  logic                  ld_rdy_q;
  logic                  cpu_hold_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  error_q;

  logic                  beat;
  logic                  start_acc;
  logic                  sum_clr;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] ld_sum;
  logic [DATA_WIDTH-1:0] vf_sum;

  assign beat      = ld_rdy_q & bus.ld_valid;
  assign start_acc = start & ((state_q == ST_IDLE) | (state_q == ST_RUN));
  assign sum_clr   = reset | start_acc;
  assign count_d   = count_q + 1'b1;
  // Address arithmetic wraps naturally at ADDR_WIDTH bits.
  assign ld_addr   = base_q + ADDR_WIDTH'(count_q);
  assign rd_addr   = base_q + ADDR_WIDTH'(rd_cnt_q);

  // Memory port mux: core owns it in RUN, loader everywhere else.
  always_comb begin
    bus.mem_addr = ld_addr;
    bus.mem_we   = 1'b0;
    bus.mem_din  = bus.ld_data;
    if (state_q == ST_RUN) begin
      bus.mem_addr = bus.cpu_addr;
      bus.mem_we   = bus.cpu_we;
      bus.mem_din  = bus.cpu_din;
    end else if (state_q == ST_VERIFY || state_q == ST_CHECK) begin
      bus.mem_addr = rd_addr;
    end else if (state_q == ST_LOAD) begin
      bus.mem_we   = beat;
    end
  end

  load_checksum #(.WIDTH(DATA_WIDTH)) u_ld_sum (
    .clk    (clk),
    .clear  (sum_clr),
    .enable (beat),
    .data   (bus.ld_data),
    .sum    (ld_sum)
  );

  load_checksum #(.WIDTH(DATA_WIDTH)) u_vf_sum (
    .clk    (clk),
    .clear  (sum_clr),
    .enable (rd_vld_q),
    .data   (bus.mem_dout),
    .sum    (vf_sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      err_q      <= ERR_NONE;
      base_q     <= '0;
      verify_q   <= 1'b0;
      count_q    <= '0;
      rd_cnt_q   <= '0;
      rd_vld_q   <= 1'b0;
      ld_rdy_q   <= 1'b0;
      cpu_hold_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      rd_vld_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_RUN: begin
          if (start_acc) begin
            state_q    <= ST_LOAD;
            base_q     <= base_addr;
            verify_q   <= verify_en;
            count_q    <= '0;
            error_q    <= 1'b0;
            err_q      <= ERR_NONE;
            ld_rdy_q   <= 1'b1;
            busy_q     <= 1'b1;
            cpu_hold_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (beat) begin
            count_q <= count_d;
            if (bus.ld_last) begin
              ld_rdy_q <= 1'b0;
              rd_cnt_q <= '0;
              if (verify_q) begin
                state_q <= ST_VERIFY;
              end else begin
                state_q    <= ST_RUN;
                busy_q     <= 1'b0;
                cpu_hold_q <= 1'b0;
                done_q     <= 1'b1;
              end
            end else if (count_d == CW'(DEPTH)) begin
              // Session ran out of room before ld_last: abort, keep core held.
              state_q  <= ST_IDLE;
              ld_rdy_q <= 1'b0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              error_q  <= 1'b1;
              err_q    <= ERR_OVERFLOW;
            end
          end
        end
        ST_VERIFY: begin
          // One read per cycle; the extra cycle after the last read lets its
          // data land in the verify sum before CHECK compares.
          if (rd_cnt_q < count_q) begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
            rd_vld_q <= 1'b1;
          end else begin
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          if (ld_sum == vf_sum) begin
            state_q    <= ST_RUN;
            cpu_hold_q <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
            error_q <= 1'b1;
            err_q   <= ERR_CHECKSUM;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ld_ready = ld_rdy_q;
  assign cpu_hold     = cpu_hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_code     = err_q;
  assign count        = count_q;

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader with a memory model and a write scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_loader;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        verify_en = 1'b0;
  logic [15:0] base_addr = '0;
  logic        cpu_hold, busy, done, error;
  logic [1:0]  err_code;
  logic [5:0]  count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit mon_en = 1'b0;
  bit corrupt_en = 1'b0;
  wr_t exp_q[$];
  logic [7:0] mem [0:65535];

  mem_loader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) bus ();

  mem_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .DEPTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .verify_en (verify_en),
    .base_addr (base_addr),
    .bus       (bus),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_code  (err_code),
    .count     (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: write on the edge, registered read data one cycle later.
  // corrupt_en forces address 0x0012 to store zero.
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1)
      mem[bus.mem_addr] <= (corrupt_en && bus.mem_addr == 16'h0012) ? 8'h00 : bus.mem_din;
    bus.mem_dout <= mem[bus.mem_addr];
  end

  // Write scoreboard and done counter.
  always @(negedge clk) begin
    wr_t w;
    if (mon_en && done === 1'b1) done_cnt++;
    if (mon_en && bus.mem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected got addr=%h din=%h required no write", bus.mem_addr, bus.mem_din);
      end else begin
        w = exp_q.pop_front();
        if (bus.mem_addr !== w.a || bus.mem_din !== w.d) begin
          errors++;
          $display("FAIL write_match got addr=%h din=%h required addr=%h din=%h", bus.mem_addr, bus.mem_din, w.a, w.d);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; start = 1'b0;
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0; bus.cpu_we = 1'b0;
    repeat (2) step();
    reset = 1'b0; corrupt_en = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] base, input logic ver);
    start = 1'b1; base_addr = base; verify_en = ver;
    step();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last, input logic [15:0] exp_a, input logic st);
    bus.ld_valid = 1'b1; bus.ld_data = d; bus.ld_last = last;
    start = st; base_addr = 16'h0080;
    exp_q.push_back('{a: exp_a, d: d});
    step();
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0; start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0; bus.ld_data = '0;
    bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
    repeat (3) step();
    @(negedge clk);
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_cpu_hold got %b want 1", cpu_hold); end
    checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready got %b want 0", bus.ld_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (error !== 1'b0 || err_code !== 2'b00) begin errors++; $display("FAIL reset_error got %b/%b want 0/00", error, err_code); end
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", bus.mem_we); end
    reset = 1'b0;
    mon_en = 1'b1;
    step();
  endtask

  task automatic test_load_run();
    logic [7:0] dat [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    int d0;
    apply_reset();
    d0 = done_cnt;
    do_start(16'h0010, 1'b0);
    for (int i = 0; i < 4; i++) send_beat(dat[i], i == 3, 16'(16'h0010 + i), 1'b0);
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL load_done got %b want 1", done); end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL load_cpu_hold got %b want 0", cpu_hold); end
    checks++; if (count !== 6'd4) begin errors++; $display("FAIL load_count got %0d want 4", count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load_busy got %b want 0", busy); end
    repeat (2) step();
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL load_done_once got %0d want 1", done_cnt - d0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL load_writes_left got %0d want 0", exp_q.size()); end
    for (int i = 0; i < 4; i++) begin
      bus.cpu_addr = 16'(16'h0010 + i); bus.cpu_we = 1'b0; bus.cpu_din = 8'hEE;
      @(negedge clk);
      checks++; if (bus.mem_addr !== bus.cpu_addr || bus.mem_we !== 1'b0) begin errors++; $display("FAIL run_pass_addr got %h/%b want %h/0", bus.mem_addr, bus.mem_we, bus.cpu_addr); end
      step();
      @(negedge clk);
      checks++; if (bus.mem_dout !== dat[i]) begin errors++; $display("FAIL run_read got %h want %h", bus.mem_dout, dat[i]); end
    end
    bus.cpu_addr = 16'h0040; bus.cpu_din = 8'h5A; bus.cpu_we = 1'b1;
    exp_q.push_back('{a: 16'h0040, d: 8'h5A});
    step();
    bus.cpu_we = 1'b0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL run_write_left got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_verify(input bit corrupt);
    logic [7:0] dat [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    int e0;
    bit seen;
    apply_reset();
    corrupt_en = corrupt;
    do_start(16'h0010, 1'b1);
    for (int i = 0; i < 4; i++) send_beat(dat[i], i == 3, 16'(16'h0010 + i), 1'b0);
    e0 = cyc;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || bus.ld_ready !== 1'b0) begin errors++; $display("FAIL vfy_busy got %b/%b want 1/0", busy, bus.ld_ready); end
    wait_done(20, seen);
    checks++; if (!seen) begin errors++; $display("FAIL vfy_done_timeout got none want done"); end
    checks++; if (cyc - e0 != 6) begin errors++; $display("FAIL vfy_latency got %0d want 6", cyc - e0); end
    checks++; if (error !== corrupt) begin errors++; $display("FAIL vfy_error got %b want %b", error, corrupt); end
    checks++; if (err_code !== (corrupt ? 2'b10 : 2'b00)) begin errors++; $display("FAIL vfy_err_code got %b want %b", err_code, corrupt ? 2'b10 : 2'b00); end
    checks++; if (cpu_hold !== corrupt) begin errors++; $display("FAIL vfy_cpu_hold got %b want %b", cpu_hold, corrupt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL vfy_busy_end got %b want 0", busy); end
    corrupt_en = 1'b0;
  endtask

  task automatic test_overflow();
    apply_reset();
    do_start(16'h0100, 1'b0);
    for (int i = 0; i < 32; i++) send_beat(8'(i * 7 + 3), 1'b0, 16'(16'h0100 + i), 1'b0);
    @(negedge clk);
    checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL ovf_ld_ready got %b want 0", bus.ld_ready); end
    checks++; if (error !== 1'b1 || err_code !== 2'b01) begin errors++; $display("FAIL ovf_error got %b/%b want 1/01", error, err_code); end
    checks++; if (done !== 1'b1 || cpu_hold !== 1'b1) begin errors++; $display("FAIL ovf_done_hold got %b/%b want 1/1", done, cpu_hold); end
    checks++; if (count !== 6'd32) begin errors++; $display("FAIL ovf_count got %0d want 32", count); end
    bus.ld_valid = 1'b1; bus.ld_data = 8'h99;
    repeat (2) step();
    bus.ld_valid = 1'b0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_writes_left got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    logic [15:0] adr [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
    logic [7:0]  dat [3] = '{8'h11, 8'h22, 8'h33};
    int e0;
    bit seen;
    apply_reset();
    do_start(16'hFFFE, 1'b1);
    for (int i = 0; i < 3; i++) send_beat(dat[i], i == 2, adr[i], 1'b0);
    e0 = cyc;
    wait_done(20, seen);
    checks++; if (!seen) begin errors++; $display("FAIL wrap_done_timeout got none want done"); end
    checks++; if (cyc - e0 != 5) begin errors++; $display("FAIL wrap_latency got %0d want 5", cyc - e0); end
    checks++; if (error !== 1'b0 || count !== 6'd3) begin errors++; $display("FAIL wrap_status got err=%b cnt=%0d want err=0 cnt=3", error, count); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_writes_left got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_abort();
    apply_reset();
    do_start(16'h0020, 1'b0);
    send_beat(8'h01, 1'b0, 16'h0020, 1'b0);
    send_beat(8'h02, 1'b0, 16'h0021, 1'b1);   // start during LOAD must be ignored
    @(negedge clk);
    checks++; if (count !== 6'd2 || bus.ld_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL abort_mid got cnt=%0d rdy=%b busy=%b want 2/1/1", count, bus.ld_ready, busy); end
    bus.cpu_addr = 16'h0055; bus.cpu_din = 8'h77; bus.cpu_we = 1'b1;   // ignored outside RUN
    reset = 1'b1;
    step();
    @(negedge clk);
    checks++; if (cpu_hold !== 1'b1 || count !== 6'd0) begin errors++; $display("FAIL abort_reset got hold=%b cnt=%0d want 1/0", cpu_hold, count); end
    checks++; if (bus.ld_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle got rdy=%b busy=%b want 0/0", bus.ld_ready, busy); end
    reset = 1'b0;
    bus.ld_valid = 1'b1; bus.ld_data = 8'h44;
    repeat (2) step();
    bus.ld_valid = 1'b0; bus.cpu_we = 1'b0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL abort_writes_left got %0d want 0", exp_q.size()); end
    checks++; if (mem[16'h0020] !== 8'h01 || mem[16'h0021] !== 8'h02) begin errors++; $display("FAIL abort_mem got %h %h want 01 02", mem[16'h0020], mem[16'h0021]); end
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_verify(1'b0);
    test_verify(1'b1);
    test_overflow();
    test_wrap();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
